// File: rtl/uncached_wbuf_pkg.sv
// Shared types and constants for the uncached posted write buffer.
// FSM encoding, AXI single-beat constants and the queued entry layout.
package uncached_wbuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] SIZE_BYTE  = 3'd0;
  localparam logic [2:0] SIZE_HALF  = 3'd1;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  localparam int ENTRY_W = 32 + 32 + 4 + 3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  size;
  } entry_t;

endpackage

// File: rtl/uncached_wbuf_fifo.sv
// Circular store queue with occupancy count and a word-address match over live entries.
// Head is read combinationally; push is refused by the parent when full, no look-ahead.
module uncached_wbuf_fifo
  import uncached_wbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  entry_t            i_entry,
  input  logic              i_pop,
  input  logic [31:2]       i_query_addr,
  output entry_t            o_head,
  output logic [PTR_W:0]    o_count,
  output logic              o_full,
  output logic              o_query_hit
);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_off;
  logic             w_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    w_hit = 1'b0;
    w_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PTR_W'(i) - r_rd_ptr;
      if (({1'b0, w_off} < r_count) && (r_mem[i].addr[31:2] == i_query_addr))
        w_hit = 1'b1;
    end
  end

  assign o_head      = r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_full      = (r_count == (PTR_W+1)'(DEPTH));
  assign o_query_hit = w_hit;

endmodule

// File: rtl/uncached_wbuf.sv
// Posted uncached store buffer draining in order as single-beat AXI writes, one outstanding.
// AW/W rise the cycle after a store lands in an empty queue; req_ready drops only when full.
module uncached_wbuf
  import uncached_wbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_strb,
  input  logic [2:0]  req_size,
  input  logic [31:0] query_addr,
  output logic        query_hit,
  output logic        empty,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  entry_t         w_req_entry;
  entry_t         w_head;
  logic [PTR_W:0] w_count;
  logic           w_full;
  logic           w_push;
  logic           w_pop;
  logic           w_aw_now;
  logic           w_w_now;
  logic           w_more;
  logic           w_unused_qa;

  state_t r_state;
  logic   r_aw_done;
  logic   r_w_done;
  logic   r_awvalid;
  logic   r_wvalid;
  logic   r_bready;

  assign req_ready   = !w_full;
  assign w_push      = req_valid & req_ready;
  assign w_pop       = (r_state == ST_RESP) & bvalid;
  assign w_req_entry = '{addr: req_addr, data: req_data, strb: req_strb, size: req_size};
  assign w_unused_qa = ^query_addr[1:0];

  uncached_wbuf_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_entry      (w_req_entry),
    .i_pop        (w_pop),
    .i_query_addr (query_addr[31:2]),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_query_hit  (query_hit)
  );

  // Handshake completion including this cycle, so AW and W may finish in either order.
  assign w_aw_now = r_aw_done | (r_awvalid & awready);
  assign w_w_now  = r_w_done  | (r_wvalid  & wready);
  assign w_more   = (w_count != (PTR_W+1)'(1)) | w_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_count != '0) begin
            r_state   <= ST_SEND;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
          end
        end
        ST_SEND: begin
          if (w_aw_now && w_w_now) begin
            r_state   <= ST_RESP;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b1;
          end else begin
            r_aw_done <= w_aw_now;
            r_w_done  <= w_w_now;
            r_awvalid <= !w_aw_now;
            r_wvalid  <= !w_w_now;
          end
        end
        ST_RESP: begin
          if (bvalid) begin
            r_bready <= 1'b0;
            if (w_more) begin
              r_state   <= ST_SEND;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
        end
      endcase
    end
  end

  assign awaddr  = w_head.addr;
  assign awsize  = w_head.size;
  assign awlen   = LEN_SINGLE;
  assign awvalid = r_awvalid;
  assign wdata   = w_head.data;
  assign wstrb   = w_head.strb;
  assign wlast   = 1'b1;
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;
  assign empty   = (w_count == '0) && (r_state == ST_IDLE);

endmodule
